// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI3 burst/response codes and bus widths
package axi_pkg;
    localparam int ID_W = 4;
    localparam int DATA_W = 32;
    localparam int LEN_W = 8;
    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_t;
    typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_t;
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next beat address; only FIXED holds, every other burst code increments
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);
    assign next_addr = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave over a word-addressed register array, one outstanding burst per channel
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);
    logic [DATA_W-1:0] mem [2**(ADDR_W-2)];
    r_state_t r_state;
    w_state_t w_state;
    logic [31:0] r_addr, r_next, w_addr, w_next;
    logic [LEN_W-1:0] r_len, r_cnt, w_len, w_cnt;
    logic [2:0] r_size, w_size;
    logic [1:0] r_burst, w_burst;
    logic [3:0] lat;
    logic w_err;
    logic unused;
    assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};
    axi_burst_addr u_r_addr (.addr(r_addr), .size(r_size), .burst(r_burst), .next_addr(r_next));
    axi_burst_addr u_w_addr (.addr(w_addr), .size(w_size), .burst(w_burst), .next_addr(w_next));
    // combinational read: a same-edge write is only seen on the following cycle
    assign rdata = rvalid ? mem[r_addr[ADDR_W-1:2]] : '0;
    assign rlast = rvalid && (r_cnt == r_len);
    assign rresp = RESP_OKAY;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            lat     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= !(arvalid && arready);
                    if (arvalid && arready) begin
                        rid     <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        lat     <= LAT_INIT;
                        rvalid  <= (RD_LATENCY == 1);
                        r_state <= (RD_LATENCY == 1) ? R_BEAT : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (lat == 4'd1) begin
                        rvalid  <= 1'b1;
                        r_state <= R_BEAT;
                    end else begin
                        lat <= lat - 4'd1;
                    end
                end
                R_BEAT: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_addr <= r_next;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= !(awvalid && awready);
                    if (awvalid && awready) begin
                        bid     <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    // the beat count ends the burst; wlast only feeds the error flag
                    if (wvalid && wready) begin
                        if (w_cnt == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_next;
                            w_err  <= w_err || wlast;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
    always_ff @(posedge aclk)
        if (wvalid && wready)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[w_addr[ADDR_W-1:2]][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized scoreboard bench with a word-array reference memory
module tb_axi_sram_slave;
    localparam int LAT = 3;
    logic aclk = 0, aresetn = 0;
    logic [3:0] arid = 0, awid = 0, wid = 0, rid, bid;
    logic [31:0] araddr = 0, awaddr = 0, wdata = 0, rdata;
    logic [7:0] arlen = 0, awlen = 0;
    logic [2:0] arsize = 0, awsize = 0, arprot = 0, awprot = 0;
    logic [1:0] arburst = 0, awburst = 0, arlock = 0, awlock = 0, rresp, bresp;
    logic [3:0] arcache = 0, awcache = 0, wstrb = 0;
    logic arvalid = 0, awvalid = 0, wvalid = 0, wlast = 0, rready = 0, bready = 0;
    logic arready, awready, wready, rvalid, rlast, bvalid;

    axi_sram_slave #(.ADDR_W(16), .RD_LATENCY(LAT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int nc = 0, nf = 0, rmode = 0;
    logic [31:0] mdl [16384];
    logic [31:0] wd [16];
    logic [3:0] ws [16];
    logic [38:0] exp_r [$];
    logic [5:0] exp_b [$];
    logic [38:0] re, r_hv;
    logic [5:0] be;
    logic r_held = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] baddr(input logic [31:0] a, input int k, input logic [2:0] sz, input logic [1:0] bt);
        return (bt == 2'b00) ? a : a + 32'(k) * (32'd1 << sz);
    endfunction

    always @(posedge aclk) begin
        #1;
        rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? !rready : 1'($urandom_range(0, 1));
        bready = 1'($urandom_range(0, 1));
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            r_held = 0;
        end else begin
            if (r_held) chk("r_hold", {rid, rresp, rdata, rlast}, r_hv);
            if (rvalid && rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    re = exp_r.pop_front();
                    chk("r_beat", {rid, rresp, rdata, rlast}, re);
                end
            end
            r_held = rvalid && !rready;
            r_hv = {rid, rresp, rdata, rlast};
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    be = exp_b.pop_front();
                    chk("b_resp", {bid, bresp}, be);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) begin
            nc++;
            nf++;
            $display("FAIL drain: %0d r and %0d b responses pending, expected 0", exp_r.size(), exp_b.size());
            exp_r.delete();
            exp_b.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [3:0] id, input int bad);
        int n;
        logic [31:0] t;
        for (int k = 0; k <= len; k++) begin
            t = baddr(a, k, sz, bt);
            for (int i = 0; i < 4; i++)
                if (ws[k][i]) mdl[t[15:2]][8*i +: 8] = wd[k][8*i +: 8];
        end
        exp_b.push_back({id, (bad >= 0) ? 2'b10 : 2'b00});
        awvalid = 1; awaddr = a; awlen = 8'(len); awsize = sz; awburst = bt; awid = id;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 100);
        if (!awready) begin nc++; nf++; $display("FAIL aw_timeout: awready 0, expected 1"); end
        @(posedge aclk); #1 awvalid = 0;
        for (int k = 0; k <= len; k++) begin
            if ($urandom_range(0, 3) == 0) begin wvalid = 0; @(posedge aclk); #1; end
            wvalid = 1; wdata = wd[k]; wstrb = ws[k]; wid = 4'($urandom);
            wlast = (k == len) != (k == bad);
            n = 0;
            do begin @(negedge aclk); n++; end while (!wready && n < 100);
            if (!wready) begin nc++; nf++; $display("FAIL w_timeout: wready 0, expected 1"); end
            @(posedge aclk); #1;
        end
        wvalid = 0; wlast = 0;
        drain();
    endtask

    task automatic issue_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                              input logic [1:0] bt, input logic [3:0] id);
        int n;
        logic [31:0] t;
        for (int k = 0; k <= len; k++) begin
            t = baddr(a, k, sz, bt);
            exp_r.push_back({id, 2'b00, mdl[t[15:2]], k == len});
        end
        arvalid = 1; araddr = a; arlen = 8'(len); arsize = sz; arburst = bt; arid = id;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 100);
        if (!arready) begin nc++; nf++; $display("FAIL ar_timeout: arready 0, expected 1"); end
        @(posedge aclk); #1 arvalid = 0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!rvalid && n < 50);
        chk("rd_latency", n, LAT);
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                           input logic [1:0] bt, input logic [3:0] id);
        issue_read(a, len, sz, bt, id);
        drain();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge aclk);
        chk("reset_outs", {arready, awready, wready, rvalid, rlast, bvalid, rid, bid, bresp, rresp, rdata}, 0);
        aresetn = 1;
        #1 chk("arready_before_edge", arready, 0);
        @(posedge aclk); #1;
        chk("arready_after_edge", {arready, awready}, 2'b11);
        for (int k = 0; k < 16; k++) begin wd[k] = 0; ws[k] = 4'hF; end
        for (int i = 0; i < 32; i++) do_write(32'(i * 64), 15, 2, 1, 4'(i), -1);
        // single beat write / read, plus an aliased address above ADDR_W
        wd[0] = 32'hDEADBEEF;
        do_write(32'h100, 0, 2, 1, 3, -1);
        do_read(32'h100, 0, 2, 1, 5);
        do_read(32'h0001_0100, 0, 2, 1, 9);
        // INCR bursts with steady and toggling rready
        for (int k = 0; k < 4; k++) wd[k] = 32'(k + 1);
        do_write(32'h200, 3, 2, 1, 1, -1);
        do_read(32'h200, 3, 2, 1, 2);
        rmode = 1;
        do_read(32'h200, 3, 2, 1, 4);
        rmode = 0;
        // partial strobes, then FIXED read
        wd[0] = 32'h11223344;
        do_write(32'h300, 0, 2, 1, 0, -1);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(32'h300, 0, 2, 1, 0, -1);
        ws[0] = 4'hF;
        do_read(32'h300, 2, 2, 0, 6);
        // early wlast, then a clean burst
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        do_write(32'h500, 3, 2, 1, 10, 2);
        do_read(32'h500, 3, 2, 1, 11);
        do_write(32'h500, 3, 2, 1, 12, -1);
        // reset during beat 2 of a 4-beat read
        issue_read(32'h200, 3, 2, 1, 13);
        n = 0;
        while (exp_r.size() != 3 && n < 100) begin @(negedge aclk); n++; end
        chk("rst_first_beat_seen", exp_r.size(), 3);
        @(posedge aclk); #2 aresetn = 0;
        #1 chk("rst_async", {rvalid, rlast, arready, awready, wready, bvalid}, 0);
        exp_r.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1;
        #1 chk("rst_release_arready", arready, 0);
        @(posedge aclk); #1 chk("rst_arready_edge", arready, 1);
        do_read(32'h200, 3, 2, 1, 14);
        // AR and AW together; the write commits on the read beat's edge
        awvalid = 1; awaddr = 32'h400; awlen = 0; awsize = 2; awburst = 1; awid = 7;
        arvalid = 1; araddr = 32'h400; arlen = 0; arsize = 2; arburst = 1; arid = 6;
        @(negedge aclk) chk("dual_ready", {arready, awready}, 2'b11);
        exp_r.push_back({4'd6, 2'b00, 32'h0, 1'b1});
        exp_b.push_back({4'd7, 2'b00});
        mdl[14'h100] = 32'h55;
        @(posedge aclk); #1 arvalid = 0; awvalid = 0;
        repeat (LAT - 1) @(posedge aclk);
        #1 wvalid = 1; wdata = 32'h55; wstrb = 4'hF; wlast = 1;
        @(negedge aclk) chk("dual_beat", {rvalid, rready, wready}, 3'b111);
        @(posedge aclk); #1 wvalid = 0; wlast = 0;
        drain();
        do_read(32'h400, 0, 2, 1, 8);
        // 32-bit address wrap with aliasing into low words
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        do_write(32'hFFFF_FFF8, 3, 2, 1, 2, -1);
        do_read(32'hFFFF_FFF8, 3, 2, 3, 3);
        // randomized traffic
        rmode = 2;
        for (int it = 0; it < 30; it++) begin
            int len, bad;
            len = $urandom_range(0, 15);
            bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
            do_write(32'($urandom_range(0, 32'h7BF)), len, 3'($urandom_range(0, 2)),
                     2'($urandom_range(0, 3)), 4'($urandom), bad);
            do_read(32'($urandom_range(0, 32'h7BF)), $urandom_range(0, 15), 3'($urandom_range(0, 2)),
                    2'($urandom_range(0, 3)), 4'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
